// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiply-accumulate engine.
package spm_pkg;

  localparam int SPM_WIDTH_DEFAULT = 32;

  // Widest accumulator the extension helper can produce.
  localparam int SPM_EXT_MAX = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    FIN  = 2'd3
  } spm_state_t;

  // Bits at and above pw are filled with 'fill' (sign bit, or 0 for zero-extension).
  function automatic logic [SPM_EXT_MAX-1:0] ext(
    input logic [SPM_EXT_MAX-1:0] p,
    input int                     pw,
    input logic                   fill
  );
    logic [SPM_EXT_MAX-1:0] r;
    for (int i = 0; i < SPM_EXT_MAX; i++) begin
      r[i] = (i < pw) ? p[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/spm_shift_add.sv
// Radix-2 shift-add datapath: one multiplier bit per step, LSB first.
// The upper half accumulates in WIDTH+1 bits, so neither signed nor unsigned sums can overflow.
module spm_shift_add
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mc,
  input  logic [WIDTH-1:0]     mp_in,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] pp_q, pp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     hi_ext;
  logic [WIDTH:0]     mc_ext;
  logic [WIDTH:0]     sum;

  assign last    = (cnt_q == '0);
  assign product = pp_q;

  always_comb begin
    pp_d   = pp_q;
    cnt_d  = cnt_q;
    hi_ext = {signed_mode & pp_q[2*WIDTH-1], pp_q[2*WIDTH-1:WIDTH]};
    mc_ext = {signed_mode & mc[WIDTH-1], mc};
    sum    = hi_ext;
    // The multiplier's sign bit carries weight -2^(WIDTH-1) in two's complement.
    if (pp_q[0]) begin
      sum = (signed_mode && last) ? (hi_ext - mc_ext) : (hi_ext + mc_ext);
    end

    if (load) begin
      pp_d  = {{WIDTH{1'b0}}, mp_in};
      cnt_d = CW'(WIDTH - 1);
    end else if (step) begin
      pp_d = {sum, pp_q[WIDTH-1:1]};
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_q  <= '0;
      cnt_q <= '0;
    end else begin
      pp_q  <= pp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spm_mac.sv
// Serial-parallel multiply-accumulate: WIDTH+2 edges start-to-done (WIDTH+3 with accumulate).
// start is ignored while busy; no queueing, operands are captured only on acceptance.
module spm_mac
  import spm_pkg::*;
#(
  parameter int WIDTH     = SPM_WIDTH_DEFAULT,
  parameter int ACC_WIDTH = 2*WIDTH + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       mc,
  input  logic [WIDTH-1:0]       mp,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     prod,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   acc_ovf
);

  spm_state_t state_q, state_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 sum_ovf_q, sum_ovf_d;
  logic [WIDTH-1:0]     mc_q, mc_d;
  logic                 sgn_q, sgn_d;
  logic                 acc_en_q, acc_en_d;

  logic                 load;
  logic                 step;
  logic                 last;
  logic [2*WIDTH-1:0]   product;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   acc_add;
  logic                 add_ovf;

  spm_shift_add #(
    .WIDTH (WIDTH)
  ) u_shift_add (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .signed_mode (sgn_q),
    .mc          (mc_q),
    .mp_in       (mp),
    .product     (product),
    .last        (last)
  );

  assign prod_ext = ACC_WIDTH'(ext(SPM_EXT_MAX'(product), 2*WIDTH,
                                   sgn_q & product[2*WIDTH-1]));

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod    = prod_q;
  assign acc     = acc_q;
  assign acc_ovf = ovf_q;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    prod_d    = prod_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    mc_d      = mc_q;
    sgn_d     = sgn_q;
    acc_en_d  = acc_en_q;
    load      = 1'b0;
    step      = 1'b0;

    acc_add = {1'b0, acc_q} + {1'b0, prod_ext};
    add_ovf = sgn_q ? ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                       (acc_add[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                    : acc_add[ACC_WIDTH];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MUL;
          busy_d   = 1'b1;
          load     = 1'b1;
          mc_d     = mc;
          sgn_d    = signed_mode;
          acc_en_d = acc_en;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) begin
          state_d = acc_en_q ? ACC : FIN;
        end
      end
      ACC: begin
        // Sum is staged so acc becomes visible on the same edge as prod and done.
        state_d = FIN;
        if (acc_clr) begin
          sum_d     = prod_ext;
          sum_ovf_d = 1'b0;
        end else begin
          sum_d     = acc_add[ACC_WIDTH-1:0];
          sum_ovf_d = ovf_q | add_ovf;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        prod_d  = product;
        if (acc_en_q) begin
          acc_d = sum_q;
          ovf_d = sum_ovf_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // In the ACC cycle the clear is already folded into the staged sum.
    if (acc_clr && (state_q != ACC)) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
      mc_q      <= '0;
      sgn_q     <= 1'b0;
      acc_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
      mc_q      <= mc_d;
      sgn_q     <= sgn_d;
      acc_en_q  <= acc_en_d;
    end
  end

endmodule

// File: tb/tb_spm_mac.sv
// Bench for spm_mac: three instances (8/24, 8/16, 32/72) against an integer-arithmetic model.
module tb_spm_mac;

  localparam int DW [3] = '{8, 8, 32};
  localparam int AW [3] = '{24, 16, 72};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  mc [3];
  logic [31:0]  mp [3];
  logic         start [3];
  logic         sm [3];
  logic         ae [3];
  logic         clr [3];
  logic         busy_o [3];
  logic         done_o [3];
  logic         ovf_o [3];
  logic [127:0] prod_v [3];
  logic [127:0] acc_v [3];

  logic [15:0] p0, p1;
  logic [63:0] p2;
  logic [23:0] a0;
  logic [15:0] a1;
  logic [71:0] a2;

  assign prod_v[0] = 128'(p0);
  assign prod_v[1] = 128'(p1);
  assign prod_v[2] = 128'(p2);
  assign acc_v[0]  = 128'(a0);
  assign acc_v[1]  = 128'(a1);
  assign acc_v[2]  = 128'(a2);

  spm_mac #(.WIDTH(8), .ACC_WIDTH(24)) dut0 (
    .clk(clk), .rst(rst), .mc(mc[0][7:0]), .mp(mp[0][7:0]), .start(start[0]),
    .signed_mode(sm[0]), .acc_en(ae[0]), .acc_clr(clr[0]), .busy(busy_o[0]),
    .done(done_o[0]), .prod(p0), .acc(a0), .acc_ovf(ovf_o[0]));

  spm_mac #(.WIDTH(8), .ACC_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .mc(mc[1][7:0]), .mp(mp[1][7:0]), .start(start[1]),
    .signed_mode(sm[1]), .acc_en(ae[1]), .acc_clr(clr[1]), .busy(busy_o[1]),
    .done(done_o[1]), .prod(p1), .acc(a1), .acc_ovf(ovf_o[1]));

  spm_mac #(.WIDTH(32)) dut2 (
    .clk(clk), .rst(rst), .mc(mc[2]), .mp(mp[2]), .start(start[2]),
    .signed_mode(sm[2]), .acc_en(ae[2]), .acc_clr(clr[2]), .busy(busy_o[2]),
    .done(done_o[2]), .prod(p2), .acc(a2), .acc_ovf(ovf_o[2]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [127:0] mask(input int n);
    return (128'd1 << n) - 128'd1;
  endfunction

  function automatic logic signed [127:0] sval(input logic [127:0] v, input int n);
    logic [127:0] m;
    m = v & mask(n);
    return m[n-1] ? ($signed(m) - $signed(128'd1 << n)) : $signed(m);
  endfunction

  function automatic logic [127:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic s);
    logic signed [127:0] x, y, p;
    x = s ? sval(128'(a), w) : $signed(128'(a) & mask(w));
    y = s ? sval(128'(b), w) : $signed(128'(b) & mask(w));
    p = x * y;
    return 128'(p) & mask(2 * w);
  endfunction

  function automatic logic [127:0] ext_ref(input logic [127:0] p, input int w, input int aw,
                                           input logic s);
    return (s ? 128'(sval(p, 2 * w)) : p) & mask(aw);
  endfunction

  // Returns {overflow, new accumulator}.
  function automatic logic [128:0] acc_ref(input logic [127:0] a, input logic [127:0] p,
                                           input int w, input int aw, input logic s);
    logic signed [127:0] t;
    logic o;
    if (s) begin
      t = sval(a, aw) + sval(p, 2 * w);
      o = (t > $signed(mask(aw - 1))) || (t < -$signed(128'd1 << (aw - 1)));
    end else begin
      t = $signed(a) + $signed(p);
      o = (t >= $signed(128'd1 << aw));
    end
    return {o, 128'(t) & mask(aw)};
  endfunction

  // ---------------- timeline model ----------------
  logic         m_busy [3], m_done [3], m_ovf [3], m_pend_ovf [3], m_sgn [3], m_ae [3];
  logic [127:0] m_prod [3], m_acc [3], m_pend [3], m_res [3];
  int           m_k [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_ovf[k] <= 1'b0; m_pend_ovf[k] <= 1'b0;
        m_sgn[k]  <= 1'b0; m_ae[k]   <= 1'b0; m_prod[k] <= '0;  m_acc[k] <= '0;
        m_pend[k] <= '0;   m_res[k]  <= '0;   m_k[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int           kk;
        logic         acc_edge;
        logic [128:0] r;
        acc_edge  = 1'b0;
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          kk = m_k[k] + 1;
          m_k[k] <= kk;
          if (m_ae[k] && kk == DW[k] + 1) begin
            acc_edge = 1'b1;
            if (clr[k]) begin
              m_pend[k]     <= ext_ref(m_res[k], DW[k], AW[k], m_sgn[k]);
              m_pend_ovf[k] <= 1'b0;
            end else begin
              r = acc_ref(m_acc[k], m_res[k], DW[k], AW[k], m_sgn[k]);
              m_pend[k]     <= r[127:0];
              m_pend_ovf[k] <= m_ovf[k] | r[128];
            end
          end
          if (kk == DW[k] + 1 + int'(m_ae[k])) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
            m_prod[k] <= m_res[k];
            if (m_ae[k]) begin
              m_acc[k] <= m_pend[k];
              m_ovf[k] <= m_pend_ovf[k];
            end
          end
        end else if (start[k]) begin
          m_busy[k] <= 1'b1;
          m_k[k]    <= 0;
          m_sgn[k]  <= sm[k];
          m_ae[k]   <= ae[k];
          m_res[k]  <= mul_ref(mc[k], mp[k], DW[k], sm[k]);
        end
        if (clr[k] && !acc_edge) begin
          m_acc[k] <= '0;
          m_ovf[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy[%0d]", k), 128'(busy_o[k]), 128'(m_busy[k]));
      check($sformatf("done[%0d]", k), 128'(done_o[k]), 128'(m_done[k]));
      check($sformatf("prod[%0d]", k), prod_v[k], m_prod[k]);
      check($sformatf("acc[%0d]", k), acc_v[k], m_acc[k]);
      check($sformatf("acc_ovf[%0d]", k), 128'(ovf_o[k]), 128'(m_ovf[k]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic e, input int clr_at, input int restart_at,
                        output logic [127:0] p_seen, output int lat, output int busy_cnt);
    int e0;
    bit seen;
    @(negedge clk);
    mc[k] = a; mp[k] = b; sm[k] = s; ae[k] = e; start[k] = 1'b1;
    e0 = cyc + 1;
    seen = 0; busy_cnt = 0; lat = -1; p_seen = '0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      start[k] = (n == restart_at);
      clr[k]   = (n == clr_at);
      if (n == restart_at) begin
        mc[k] = a ^ 32'h5A; mp[k] = b ^ 32'hC3; sm[k] = ~s; ae[k] = ~e;
      end
      if (busy_o[k]) busy_cnt++;
      if (done_o[k]) begin
        seen   = 1;
        lat    = cyc - e0;
        p_seen = prod_v[k];
      end
    end
    start[k] = 1'b0;
    clr[k]   = 1'b0;
    if (!seen) check("done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p;
    int lat, bc, d1, d2, e0;
    bit seen;
    for (int k = 0; k < 3; k++) begin
      mc[k] = '0; mp[k] = '0; start[k] = 0; sm[k] = 0; ae[k] = 0; clr[k] = 0;
    end
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy_o[0]), 128'(0));
    check("rst_done", 128'(done_o[0]), 128'(0));
    check("rst_prod", prod_v[0], 128'(0));
    check("rst_acc", acc_v[0], 128'(0));
    check("rst_ovf", 128'(ovf_o[0]), 128'(0));
    rst = 1'b0;

    // Unsigned 0xFF*0xFF, no accumulate.
    run_op(0, 32'hFF, 32'hFF, 0, 0, 0, 0, p, lat, bc);
    check("u_ff_ff_prod", p, 128'hFE01);
    check("u_ff_ff_done_edge", 128'(lat), 128'(9));
    check("u_ff_ff_busy_cycles", 128'(bc), 128'(9));
    check("u_ff_ff_acc_untouched", acc_v[0], 128'(0));

    // Signed corner operands.
    run_op(0, 32'h80, 32'hFF, 1, 0, 0, 0, p, lat, bc);
    check("s_80_ff_prod", p, 128'h0080);
    run_op(0, 32'h80, 32'h7F, 1, 0, 0, 0, p, lat, bc);
    check("s_80_7f_prod", p, 128'hC080);

    // Signed accumulate: 15 - 14 + 10000.
    @(negedge clk); clr[0] = 1'b1;
    @(negedge clk); clr[0] = 1'b0;
    run_op(0, 32'd3, 32'd5, 1, 1, 0, 0, p, lat, bc);
    check("acc_done_edge", 128'(lat), 128'(10));
    run_op(0, 32'hFE, 32'd7, 1, 1, 0, 0, p, lat, bc);
    run_op(0, 32'd100, 32'd100, 1, 1, 0, 0, p, lat, bc);
    check("s_acc_sum", acc_v[0], 128'h002711);
    check("s_acc_ovf", 128'(ovf_o[0]), 128'(0));

    // Unsigned 16-bit accumulator overflow, then clear inside the ACC cycle, then plain clear.
    run_op(1, 32'hFF, 32'hFF, 0, 1, 0, 0, p, lat, bc);
    run_op(1, 32'hFF, 32'hFF, 0, 1, 0, 0, p, lat, bc);
    check("u_acc_wrap", acc_v[1], 128'hFC02);
    check("u_acc_ovf_set", 128'(ovf_o[1]), 128'(1));
    run_op(1, 32'h10, 32'h10, 0, 1, 9, 0, p, lat, bc);
    check("clr_in_acc_value", acc_v[1], 128'h0100);
    check("clr_in_acc_ovf", 128'(ovf_o[1]), 128'(0));
    run_op(1, 32'hFF, 32'hFF, 0, 1, 0, 0, p, lat, bc);
    @(negedge clk); clr[1] = 1'b1;
    @(negedge clk); clr[1] = 1'b0;
    check("clr_acc", acc_v[1], 128'(0));
    check("clr_ovf", 128'(ovf_o[1]), 128'(0));

    // Second start while busy must be ignored.
    run_op(0, 32'h12, 32'h34, 0, 0, 0, 3, p, lat, bc);
    check("ignored_start_prod", p, 128'h03A8);
    check("ignored_start_done_edge", 128'(lat), 128'(9));

    // Reset mid-operation.
    @(negedge clk);
    mc[0] = 32'hFF; mp[0] = 32'hFF; sm[0] = 0; ae[0] = 1; start[0] = 1;
    @(negedge clk); start[0] = 0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 128'(busy_o[0]), 128'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy", 128'(busy_o[0]), 128'(0));
    check("rst_mid_prod", prod_v[0], 128'(0));
    check("rst_mid_acc", acc_v[0], 128'(0));
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o[0]) seen = 1;
    end
    check("rst_mid_no_done", 128'(seen), 128'(0));

    // WIDTH=32 back-to-back issue with start held through the done cycle.
    @(negedge clk);
    mc[2] = 32'hFFFFFFFF; mp[2] = 32'hFFFFFFFF; sm[2] = 0; ae[2] = 0; start[2] = 1;
    e0 = cyc + 1; d1 = -1; d2 = -1;
    for (int n = 1; n <= 200 && d2 < 0; n++) begin
      @(negedge clk);
      if (done_o[2]) begin
        check("w32_prod", prod_v[2], 128'hFFFFFFFE00000001);
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          start[2] = 0;
        end
      end
    end
    start[2] = 0;
    check("w32_first_done_edge", 128'(d1 - e0), 128'(33));
    check("w32_b2b_spacing", 128'(d2 - d1), 128'(34));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
